// File: rtl/mac_stream_ctrl_pkg.sv
// Shared types and helpers for the MAC stream controller: FSM state encoding
// and the sizing rule for the latency wait counter.
package mac_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    ACC,
    DRAIN,
    CAPTURE,
    CLEAR
  } mac_stream_state_t;

  // Width that can hold the larger of the two latency waits; never narrower than 1 bit.
  function automatic int wait_cnt_width(input int pipe_lat, input int clr_lat);
    int max_lat;
    max_lat = (pipe_lat > clr_lat) ? pipe_lat : clr_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/mac_stream_ctrl_res_fifo.sv
// Small synchronous result FIFO with a registered head word: rd_data is 0 when
// empty and only changes on a pop or on a push into an empty FIFO.
module res_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign rd_data = head_q;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_nxt;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The head register must already hold the next entry when the current one leaves.
    if (pop) begin
      if (count_q > CW'(1)) head_d = mem[rd_nxt];
      else if (push)        head_d = wr_data;
      else                  head_d = '0;
    end else if (push && empty) begin
      head_d = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mac_stream_ctrl.sv
// Stream controller around an input-registered MAC: windows upstream beats,
// waits out the MAC latency, captures z into a result FIFO and clears the MAC.
module mac_stream_ctrl
  import mac_stream_ctrl_pkg::*;
#(
  parameter int N_A        = 1,
  parameter int N_W        = 1,
  parameter int Z_WIDTH    = 20,
  parameter int LEN_W      = 8,
  parameter int PIPE_LAT   = 2,
  parameter int CLR_LAT    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               start,
  input  logic               stop,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [8*N_A-1:0]   a_in,
  input  logic [8*N_W-1:0]   w_in,
  output logic [8*N_A-1:0]   a_out,
  output logic [8*N_W-1:0]   w_out,
  output logic               mac_clr,
  input  logic [Z_WIDTH-1:0] z,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [Z_WIDTH-1:0] res_data,
  output logic               busy
);

  localparam int                WAIT_W    = wait_cnt_width(PIPE_LAT, CLR_LAT);
  localparam logic [WAIT_W-1:0] PIPE_LOAD = WAIT_W'(PIPE_LAT - 1);
  localparam logic [WAIT_W-1:0] CLR_LOAD  = WAIT_W'(CLR_LAT);

  mac_stream_state_t state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stop_pend_q, stop_pend_d;
  logic              beat, fifo_push, fifo_full, fifo_empty;

  assign beat  = op_valid && op_ready;
  // The MAC registers its inputs, so gating is combinational only.
  assign a_out = beat ? a_in : '0;
  assign w_out = beat ? w_in : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_CLR;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      wait_q      <= CLR_LOAD;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wait_q      <= wait_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wait_d      = wait_q;
    stop_pend_d = stop_pend_q;
    if (stop && state_q != IDLE) stop_pend_d = 1'b1;
    unique case (state_q)
      INIT_CLR: if (wait_q == '0) state_d = IDLE; else wait_d = wait_q - WAIT_W'(1);
      IDLE: begin
        if (start) begin
          len_d       = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = ACC;
        end
      end
      ACC: begin
        if (beat) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            wait_d  = PIPE_LOAD;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DRAIN: if (wait_q == '0) state_d = CAPTURE; else wait_d = wait_q - WAIT_W'(1);
      // Operands are forced to zero here, so z holds steady while the FIFO is full.
      CAPTURE: begin
        if (!fifo_full) begin
          wait_d  = CLR_LOAD;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (wait_q == '0) state_d = stop_pend_q ? IDLE : ACC;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      default: state_d = INIT_CLR;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == ACC);
    busy      = (state_q != IDLE);
    mac_clr   = (state_q == INIT_CLR || state_q == CLEAR) && (wait_q == CLR_LOAD);
    fifo_push = (state_q == CAPTURE) && !fifo_full;
  end

  res_fifo #(
    .WIDTH (Z_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (fifo_push),
    .wr_data (z),
    .rd_en   (res_ready),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (res_data)
  );

  assign res_valid = !fifo_empty;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Bench for mac_stream_ctrl: a behavioural input-registered MAC closes the z loop,
// and a window-sum model predicts every result popped from the output FIFO.
module tb_mac_stream_ctrl;

  localparam int Z_WIDTH = 20;
  localparam int LEN_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               start = 1'b0, stop = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [7:0]         a_in = '0, w_in = '0;
  logic               op_ready, mac_clr, res_valid, busy;
  logic [7:0]         a_out, w_out;
  logic [Z_WIDTH-1:0] z, res_data;

  always #5 clk = ~clk;

  mac_stream_ctrl #(
    .N_A(1), .N_W(1), .Z_WIDTH(Z_WIDTH), .LEN_W(LEN_W),
    .PIPE_LAT(2), .CLR_LAT(2), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .start(start), .stop(stop),
    .op_valid(op_valid), .op_ready(op_ready), .a_in(a_in), .w_in(w_in),
    .a_out(a_out), .w_out(w_out), .mac_clr(mac_clr), .z(z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // MAC stand-in: registered operands, accumulator cleared two cycles after mac_clr.
  logic               m_clr_q = 1'b0;
  logic [7:0]         m_a_q = '0, m_w_q = '0;
  logic [Z_WIDTH-1:0] m_acc = 20'h12345;
  always @(posedge clk) begin
    m_clr_q <= mac_clr;
    m_a_q   <= a_out;
    m_w_q   <= w_out;
    m_acc   <= m_clr_q ? '0 : m_acc + Z_WIDTH'(m_a_q) * Z_WIDTH'(m_w_q);
  end
  assign z = m_acc;

  int n_checks = 0, n_errors = 0, cyc = 0, clr_cnt = 0;
  int m_len = 1, m_cnt = 0;
  logic [Z_WIDTH-1:0] m_sum = '0;
  logic [Z_WIDTH-1:0] exp_q[$];
  logic [Z_WIDTH-1:0] got_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle compare against the window-sum model.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_sum = '0;
    end else begin
      check("a_out_gate", a_out, (op_valid && op_ready) ? a_in : 8'd0);
      check("w_out_gate", w_out, (op_valid && op_ready) ? w_in : 8'd0);
      check("ready_while_idle", op_ready && !busy, 0);
      if (mac_clr) clr_cnt++;
      if (op_valid && op_ready) begin
        m_sum = m_sum + Z_WIDTH'(int'(a_in) * int'(w_in));
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back(m_sum);
          m_sum = '0;
          m_cnt = 0;
        end
      end
      if (res_valid && res_ready) begin
        got_q.push_back(res_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_result: got %0d expected no result (t=%0t)", res_data, $time);
        end else begin
          check("res_data", res_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic start_win(input logic [LEN_W-1:0] len);
    cfg_len = len;
    m_len   = (len == 0) ? 1 : int'(len);
    m_cnt   = 0;
    m_sum   = '0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    cfg_len = 8'hAA;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] w, input bit do_stop,
                           output int acc_cyc);
    int n = 0;
    op_valid = 1'b1;
    a_in     = a;
    w_in     = w;
    acc_cyc  = -1;
    while (!op_ready && n < 200) begin
      step();
      n++;
    end
    if (!op_ready) begin
      check("beat_accept", op_ready, 1);
      op_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      stop    = do_stop;
      step();
      stop    = 1'b0;
    end
  endtask

  task automatic bubble(input logic [7:0] a, input logic [7:0] w);
    op_valid = 1'b0;
    a_in     = a;
    w_in     = w;
    #1;
    check("bubble_a_out", a_out, 0);
    check("bubble_w_out", w_out, 0);
    step();
  endtask

  task automatic check_got(input string nm, input int idx, input logic [31:0] exp);
    if (idx < got_q.size()) check(nm, got_q[idx], exp);
    else                    check({nm, "_missing"}, got_q.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, tmp;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_op_ready", op_ready, 0);
    check("rst_mac_clr", mac_clr, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    repeat (3) step();
    rst = 1'b1;
    clr_cnt = 0;
    wait_idle();
    check("init_clr_pulses", clr_cnt, 1);
    check("init_z_cleared", z, 0);

    // 1: len 4, a=1..4, w=2 -> 20, window span 10 cycles
    res_ready = 1'b1;
    got_q.delete();
    clr_cnt = 0;
    start_win(8'd4);
    send_beat(8'd1, 8'd2, 1'b0, t0);
    send_beat(8'd2, 8'd2, 1'b1, tmp);
    send_beat(8'd3, 8'd2, 1'b0, tmp);
    send_beat(8'd4, 8'd2, 1'b0, tmp);
    op_valid = 1'b0;
    wait_idle();
    t1 = cyc;
    check("t1_window_span", t1 - t0, 10);
    check_got("t1_result", 0, 20);
    check("t1_result_count", got_q.size(), 1);
    check("t1_clr_pulses", clr_cnt, 1);
    check("t1_res_valid", res_valid, 0);

    // 2: cfg_len 0 acts as 1: 63, 63, then 1
    got_q.delete();
    clr_cnt = 0;
    start_win(8'd0);
    send_beat(8'd7, 8'd9, 1'b0, tmp);
    send_beat(8'd7, 8'd9, 1'b0, tmp);
    send_beat(8'd1, 8'd1, 1'b1, tmp);
    op_valid = 1'b0;
    wait_idle();
    check_got("t2_r0", 0, 63);
    check_got("t2_r1", 1, 63);
    check_got("t2_r2", 2, 1);
    check("t2_result_count", got_q.size(), 3);
    check("t2_clr_pulses", clr_cnt, 3);

    // 3: backpressure, three len-2 windows of 18 with res_ready low
    got_q.delete();
    res_ready = 1'b0;
    start_win(8'd2);
    for (int i = 0; i < 6; i++) send_beat(8'd3, 8'd3, i == 5, tmp);
    op_valid = 1'b0;
    repeat (15) step();
    check("t3_stall_busy", busy, 1);
    check("t3_stall_ready", op_ready, 0);
    check("t3_stall_valid", res_valid, 1);
    check("t3_stall_head", res_data, 18);
    check("t3_nothing_popped", got_q.size(), 0);
    res_ready = 1'b1;
    wait_idle();
    for (int i = 0; i < 3; i++) check_got("t3_drain", i, 18);
    check("t3_result_count", got_q.size(), 3);

    // 4: len 3 with bubbles, 5*5*3 = 75
    got_q.delete();
    start_win(8'd3);
    send_beat(8'd5, 8'd5, 1'b0, tmp);
    bubble(8'd5, 8'd5);
    send_beat(8'd5, 8'd5, 1'b0, tmp);
    bubble(8'd5, 8'd5);
    send_beat(8'd5, 8'd5, 1'b1, tmp);
    op_valid = 1'b0;
    wait_idle();
    check_got("t4_result", 0, 75);
    check("t4_result_count", got_q.size(), 1);

    // 5: stop on beat 2 of 4 -> 4, then idle; later start resumes
    got_q.delete();
    start_win(8'd4);
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, i == 1, tmp);
    op_valid = 1'b0;
    wait_idle();
    repeat (5) step();
    check("t5_stays_idle", busy, 0);
    check_got("t5_result", 0, 4);
    start_win(8'd1);
    send_beat(8'd2, 8'd3, 1'b1, tmp);
    op_valid = 1'b0;
    wait_idle();
    check_got("t5_resume", 1, 6);
    check("t5_result_count", got_q.size(), 2);

    // 6: reset during DRAIN, then a fresh len-1 window 2*2 = 4
    start_win(8'd2);
    send_beat(8'd4, 8'd4, 1'b0, tmp);
    send_beat(8'd4, 8'd4, 1'b0, tmp);
    op_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_rst_op_ready", op_ready, 0);
    check("t6_rst_mac_clr", mac_clr, 1);
    check("t6_rst_res_valid", res_valid, 0);
    check("t6_rst_res_data", res_data, 0);
    check("t6_rst_busy", busy, 1);
    repeat (2) step();
    rst = 1'b1;
    clr_cnt = 0;
    got_q.delete();
    wait_idle();
    check("t6_init_clr_pulses", clr_cnt, 1);
    start_win(8'd1);
    send_beat(8'd2, 8'd2, 1'b1, tmp);
    op_valid = 1'b0;
    wait_idle();
    check_got("t6_result", 0, 4);
    check("t6_result_count", got_q.size(), 1);
    check("t6_no_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
